regfile_sb: RTL and testbench

Parametrised, clocked register file with a built-in write scoreboard for the CSE-BUBBLE processor. Holds NUM_RD combinational read ports, one synchronous write port and a per-register pending-write (busy) bit set when an instruction claims a destination and cleared by its writeback. Sits between decode (reads, issue claims) and writeback, and gives decode the busy/stall information directly. Replaces the fixed 32×32, PC-triggered register file.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/regfile_sb.sv | 68 ++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, types and helpers for the regfile_sb register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_t;

  // True for an address that names real, writable storage (not r0, not past the end).
  function automatic logic addr_live(input int unsigned addr, input int unsigned depth);
    return (addr != 0) && (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of regfile_sb: read ports, writeback port, issue claim and scoreboard status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ok;
  logic [DEPTH-1:0]         busy_vec;
  logic [CNT_W-1:0]         pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, iss_ok, busy_vec, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, iss_ok, busy_vec, pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, claim acceptance and a running count of busy bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ok,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [CNT_W-1:0]  pend_cnt
);

  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  cnt_op_t          cnt_op;

  // A claim sees the pre-edge busy bit, so a claim racing the write that frees
  // the same register is refused; set and clear can therefore never collide.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    iss_ok   = 1'b0;
    set_mask = '0;
    clr_mask = '0;
    if (iss_en && addr_live(32'(iss_addr), DEPTH) && !busy_vec[iss_addr]) begin
      iss_ok             = 1'b1;
      set_mask[iss_addr] = 1'b1;
    end
    if (wr_en && addr_live(32'(wr_addr), DEPTH) && busy_vec[wr_addr]) begin
      clr_mask[wr_addr] = 1'b1;
    end
    case ({iss_ok, |clr_mask})
      2'b10:   cnt_op = CNT_INC;
      2'b01:   cnt_op = CNT_DEC;
      default: cnt_op = CNT_HOLD;
    endcase
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values; comb logic uses =.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      pend_cnt <= '0;
    end else begin
      busy_vec <= (busy_vec & ~clr_mask) | set_mask;
      case (cnt_op)
        CNT_INC: pend_cnt <= pend_cnt + CNT_W'(1);
        CNT_DEC: pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational reads, one writeback port and a write scoreboard.
// Optional `REGFILE_BYPASS_EN forwards same-cycle writeback data and clears busy on matching reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_sb_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_live;
  logic [ADDR_W-1:0] ra;

  assign wr_live = bus.wr_en && addr_live(32'(bus.wr_addr), DEPTH);

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .iss_ok   (bus.iss_ok),
    .busy_vec (bus.busy_vec),
    .pend_cnt (bus.pend_cnt)
  );

  // NOTE: the storage array is reset because reset must clear architectural state, not just control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // r0 and out-of-range addresses read as zero and never busy.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      if (addr_live(32'(ra), DEPTH)) begin
        bus.rd_data[k*DATA_W +: DATA_W] = mem[ra];
        bus.rd_busy[k]                  = bus.busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (bus.wr_addr == ra)) begin
          bus.rd_data[k*DATA_W +: DATA_W] = bus.wr_data;
          bus.rd_busy[k]                  = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic against an array model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) bus ();

  regfile_sb #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] m_mem  [D];
  bit            m_busy [D];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit fwd_hit(input int a);
`ifdef REGFILE_BYPASS_EN
    return bus.wr_en && (int'(bus.wr_addr) == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (a == 0 || a >= D) return '0;
    if (fwd_hit(a)) return bus.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0 || a >= D) return 1'b0;
    if (fwd_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_iss_ok();
    int a = int'(bus.iss_addr);
    return bus.iss_en && a != 0 && a < D && !m_busy[a];
  endfunction

  task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic ie, input int ia, input int r0, input int r1);
    bus.wr_en    = we;
    bus.wr_addr  = AW'(wa);
    bus.wr_data  = wd;
    bus.iss_en   = ie;
    bus.iss_addr = AW'(ia);
    bus.rd_addr  = {AW'(r1), AW'(r0)};
  endtask

  // Settle mid-cycle and compare every output against the model's pre-edge view.
  task automatic settle(input string tag);
    logic [D-1:0] bv;
    @(negedge clk);
    for (int i = 0; i < D; i++) bv[i] = m_busy[i];
    check({tag, ".iss_ok"}, 64'(bus.iss_ok), 64'(exp_iss_ok()));
    check({tag, ".busy_vec"}, 64'(bus.busy_vec), 64'(bv));
    check({tag, ".pend_cnt"}, 64'(bus.pend_cnt), 64'(popcount()));
    for (int k = 0; k < NR; k++) begin
      int a = int'(bus.rd_addr[k*AW +: AW]);
      check($sformatf("%s.rd_data%0d", tag, k), 64'(bus.rd_data[k*DW +: DW]), 64'(exp_data(a)));
      check($sformatf("%s.rd_busy%0d", tag, k), 64'(bus.rd_busy[k]), 64'(exp_busy(a)));
    end
  endtask

  // Clock edge: the claim decision uses pre-edge busy bits; r0 is never written.
  task automatic tick();
    bit acc = exp_iss_ok();
    int wa  = int'(bus.wr_addr);
    int ia  = int'(bus.iss_addr);
    @(posedge clk);
    if (bus.wr_en && wa != 0 && wa < D) begin
      m_mem[wa]  = bus.wr_data;
      m_busy[wa] = 1'b0;
    end
    if (acc) m_busy[ia] = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, '0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy_vec", 64'(bus.busy_vec), 64'd0);
    check("rst.pend_cnt", 64'(bus.pend_cnt), 64'd0);
    drive(0, 0, '0, 1, 3, 5, 31);
    #1;
    check("rst.rd_data", 64'(bus.rd_data), 64'd0);
    check("rst.iss_ok_follows_en", 64'(bus.iss_ok), 64'd1);
    drive(0, 0, '0, 0, 0, 5, 31);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0);
    settle("wr_r5");
    tick();
    drive(0, 0, '0, 0, 0, 5, 0);
    settle("rd_r5");
    check("rd_r5.value", 64'(bus.rd_data[DW-1:0]), 64'hDEAD_BEEF);
    tick();

    drive(0, 0, '0, 1, 7, 7, 0);
    settle("claim_r7");
    check("claim_r7.ok", 64'(bus.iss_ok), 64'd1);
    tick();
    settle("reclaim_r7");
    check("reclaim_r7.rejected", 64'(bus.iss_ok), 64'd0);
    check("reclaim_r7.busy7", 64'(bus.busy_vec[7]), 64'd1);
    check("reclaim_r7.pend", 64'(bus.pend_cnt), 64'd1);
    tick();
    drive(0, 0, '0, 0, 0, 7, 0);
    settle("after_reclaim");
    check("after_reclaim.pend", 64'(bus.pend_cnt), 64'd1);
    tick();

    drive(1, 7, 32'h12, 1, 9, 7, 9);
    settle("wr7_claim9");
    tick();
    drive(0, 0, '0, 0, 0, 7, 9);
    settle("post_wr7_claim9");
    check("post_wr7_claim9.busy7", 64'(bus.busy_vec[7]), 64'd0);
    check("post_wr7_claim9.busy9", 64'(bus.busy_vec[9]), 64'd1);
    check("post_wr7_claim9.pend", 64'(bus.pend_cnt), 64'd1);
    check("post_wr7_claim9.r7", 64'(bus.rd_data[DW-1:0]), 64'h12);
    tick();

    drive(1, 0, 32'hFFFF, 1, 0, 0, 0);
    settle("r0_wr_claim");
    check("r0_wr_claim.iss_ok", 64'(bus.iss_ok), 64'd0);
    tick();
    drive(0, 0, '0, 0, 0, 0, 0);
    settle("r0_after");
    check("r0_after.read", 64'(bus.rd_data[DW-1:0]), 64'd0);
    check("r0_after.busy0", 64'(bus.busy_vec[0]), 64'd0);
    tick();

    drive(1, 9, 32'h99, 1, 9, 9, 0);
    settle("waw_same_cycle");
    check("waw_same_cycle.iss_ok", 64'(bus.iss_ok), 64'd0);
    tick();

    drive(1, 3, 32'h11, 0, 0, 3, 0);
    settle("r3_old");
    tick();
    drive(1, 3, 32'hA5, 0, 0, 3, 3);
    settle("r3_fwd");
`ifdef REGFILE_BYPASS_EN
    check("r3_fwd.same_cycle", 64'(bus.rd_data[DW-1:0]), 64'hA5);
`else
    check("r3_fwd.same_cycle", 64'(bus.rd_data[DW-1:0]), 64'h11);
`endif
    tick();
    drive(0, 0, '0, 0, 0, 3, 0);
    settle("r3_next");
    check("r3_next.value", 64'(bus.rd_data[DW-1:0]), 64'hA5);
    tick();

    drive(1, 4, 32'h44, 1, 4, 4, 6);
    tick();
    drive(1, 6, 32'h66, 1, 6, 4, 6);
    tick();
    drive(0, 0, '0, 0, 0, 4, 6);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst.busy_vec", 64'(bus.busy_vec), 64'd0);
    check("mid_rst.pend_cnt", 64'(bus.pend_cnt), 64'd0);
    check("mid_rst.r4", 64'(bus.rd_data[DW-1:0]), 64'd0);
    check("mid_rst.r6", 64'(bus.rd_data[2*DW-1:DW]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      int wa = int'($urandom_range(0, D - 1));
      int r0 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, D - 1));
      int r1 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, D - 1));
      drive(logic'($urandom_range(0, 1)), wa, DW'($urandom),
            logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, D - 1)), r0, r1);
      settle($sformatf("rnd%0d", n));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
